// File: rtl/axi_lite_cmd_fifo.sv
// axi_lite_cmd_fifo: command FIFO in front of the AXI-lite master that filters malformed tkeep patterns
module axi_lite_cmd_fifo #(
    parameter int DATA_WD           = 8,
    parameter int ADDR_WD           = 8,
    parameter int DATA_ADDR_BYTE_WD = (DATA_WD + ADDR_WD) >> 3,
    parameter int DEPTH             = 16,
    parameter int CNT_WD            = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_tvalid,
    input  logic [ADDR_WD+DATA_WD-1:0]   s_tdata,
    input  logic [DATA_ADDR_BYTE_WD-1:0] s_tkeep,
    output logic                         s_tready,
    output logic                         m_tvalid,
    output logic [ADDR_WD+DATA_WD-1:0]   m_tdata,
    output logic [DATA_ADDR_BYTE_WD-1:0] m_tkeep,
    input  logic                         m_tready,
    output logic [CNT_WD-1:0]            count,
    output logic                         drop_pulse,
    output logic [15:0]                  drop_cnt
);
    localparam int TW = ADDR_WD + DATA_WD;
    localparam int KW = DATA_ADDR_BYTE_WD;
    localparam int PW = $clog2(DEPTH);
    localparam logic [KW-1:0] KEEP_WR = '1;
    localparam logic [KW-1:0] KEEP_RD = {{(ADDR_WD/8){1'b1}}, {(DATA_WD/8){1'b0}}};
    logic [KW+TW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             s_fire, m_fire, legal, push, drop;
    assign s_tready = !rst && (count != CNT_WD'(DEPTH));
    assign m_tvalid = count != '0;
    assign s_fire   = s_tvalid && s_tready;
    assign m_fire   = m_tvalid && m_tready;
    assign legal    = (s_tkeep == KEEP_WR) || (s_tkeep == KEEP_RD);
    assign push     = s_fire && legal;
    assign drop     = s_fire && !legal;
    // Head is forced to zero while empty so stale array contents never leak out.
    assign {m_tkeep, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_tkeep, s_tdata};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(m_fire);
            count      <= count + CNT_WD'(push) - CNT_WD'(m_fire);
            drop_pulse <= drop;
            drop_cnt   <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_axi_lite_cmd_fifo.sv
// tb_axi_lite_cmd_fifo: vector table, directed corner sequences and random streaming against a queue model
module tb_axi_lite_cmd_fifo;
    logic        clk = 1'b0;
    logic        rst, s_tvalid, s_tready, m_tvalid, m_tready, drop_pulse;
    logic [15:0] s_tdata, m_tdata, drop_cnt;
    logic [1:0]  s_tkeep, m_tkeep;
    logic [4:0]  count;

    always #5 clk = ~clk;

    axi_lite_cmd_fifo dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tready(m_tready),
        .count(count), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    int          n_chk = 0, n_fail = 0;
    logic [17:0] q[$];
    logic [15:0] rx[$];
    int          m_dcnt = 0;
    bit          m_dpulse = 0;

    typedef struct {
        bit rst, v; logic [15:0] d; logic [1:0] k; bit mr;
        int cnt; bit mtv, str, dp; int dc; logic [15:0] md; logic [1:0] mk;
    } vec_t;
    vec_t tbl[13];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and compare every output against the queue-based model.
    task automatic tick(output bit sf);
        bit mf, lg;
        sf = !rst && s_tvalid && q.size() < 16;
        mf = !rst && m_tready && q.size() > 0;
        lg = (s_tkeep == 2'b11) || (s_tkeep == 2'b10);
        if (mf) rx.push_back(m_tdata);
        @(posedge clk); #1;
        if (rst) begin
            q.delete(); m_dcnt = 0; m_dpulse = 0;
        end else begin
            if (mf) void'(q.pop_front());
            if (sf && lg) q.push_back({s_tkeep, s_tdata});
            m_dpulse = sf && !lg;
            if (m_dpulse && m_dcnt < 16'hFFFF) m_dcnt++;
        end
        check("model_count", 32'(count), 32'(q.size()));
        check("model_s_tready", 32'(s_tready), 32'(!rst && q.size() != 16));
        check("model_m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
        check("model_m_tdata", 32'(m_tdata), q.size() != 0 ? 32'(q[0][15:0]) : 32'h0);
        check("model_m_tkeep", 32'(m_tkeep), q.size() != 0 ? 32'(q[0][17:16]) : 32'h0);
        check("model_drop_pulse", 32'(drop_pulse), 32'(m_dpulse));
        check("model_drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    endtask

    task automatic step();
        bit sf;
        tick(sf);
    endtask

    initial begin
        bit sf;
        int sent, cyc;
        tbl[0]  = '{1, 1, 16'h0101, 2'b11, 0, 0, 0, 0, 0, 0, 16'h0000, 2'b00};
        tbl[1]  = '{1, 1, 16'h0101, 2'b11, 0, 0, 0, 0, 0, 0, 16'h0000, 2'b00};
        tbl[2]  = '{1, 1, 16'h0101, 2'b11, 0, 0, 0, 0, 0, 0, 16'h0000, 2'b00};
        tbl[3]  = '{0, 1, 16'h0101, 2'b11, 0, 1, 1, 1, 0, 0, 16'h0101, 2'b11};
        tbl[4]  = '{0, 1, 16'h1234, 2'b01, 0, 1, 1, 1, 1, 1, 16'h0101, 2'b11};
        tbl[5]  = '{0, 1, 16'h5678, 2'b00, 0, 1, 1, 1, 1, 2, 16'h0101, 2'b11};
        tbl[6]  = '{0, 1, 16'h2200, 2'b10, 0, 2, 1, 1, 0, 2, 16'h0101, 2'b11};
        tbl[7]  = '{0, 0, 16'h0000, 2'b11, 1, 1, 1, 1, 0, 2, 16'h2200, 2'b10};
        tbl[8]  = '{0, 0, 16'h0000, 2'b11, 1, 0, 0, 1, 0, 2, 16'h0000, 2'b00};
        tbl[9]  = '{0, 1, 16'h0303, 2'b11, 1, 1, 1, 1, 0, 2, 16'h0303, 2'b11};
        tbl[10] = '{0, 1, 16'h0404, 2'b11, 1, 1, 1, 1, 0, 2, 16'h0404, 2'b11};
        tbl[11] = '{0, 0, 16'h0000, 2'b11, 0, 1, 1, 1, 0, 2, 16'h0404, 2'b11};
        tbl[12] = '{0, 0, 16'h0000, 2'b11, 0, 1, 1, 1, 0, 2, 16'h0404, 2'b11};
        rst = 1; s_tvalid = 0; s_tdata = 0; s_tkeep = 0; m_tready = 0;
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; s_tvalid = tbl[i].v; s_tdata = tbl[i].d;
            s_tkeep = tbl[i].k; m_tready = tbl[i].mr;
            step();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].mtv));
            check($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(tbl[i].str));
            check($sformatf("vec%0d_drop_pulse", i), 32'(drop_pulse), 32'(tbl[i].dp));
            check($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].dc));
            check($sformatf("vec%0d_m_tdata", i), 32'(m_tdata), 32'(tbl[i].md));
            check($sformatf("vec%0d_m_tkeep", i), 32'(m_tkeep), 32'(tbl[i].mk));
        end

        s_tvalid = 0; m_tready = 1;
        repeat (3) step();
        check("drain_empty", 32'(count), 32'd0);
        m_tready = 0; s_tvalid = 1; s_tkeep = 2'b11;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 16'h1000 + 16'(i);
            step();
        end
        check("full_count", 32'(count), 32'd16);
        check("full_s_tready", 32'(s_tready), 32'd0);
        s_tdata = 16'hBEEF;
        step();
        check("full_17th_held", 32'(count), 32'd16);
        check("full_head", 32'(m_tdata), 32'h1000);
        s_tvalid = 0; m_tready = 1;
        step();
        check("unfull_count", 32'(count), 32'd15);
        check("unfull_s_tready", 32'(s_tready), 32'd1);
        check("unfull_head", 32'(m_tdata), 32'h1001);

        repeat (16) step();
        m_tready = 0; s_tvalid = 1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 16'h2000 + 16'(i);
            step();
        end
        check("midrst_pre_count", 32'(count), 32'd5);
        s_tvalid = 0; rst = 1;
        step();
        rst = 0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        s_tvalid = 1; s_tdata = 16'hAA55;
        step();
        s_tvalid = 0;
        check("midrst_post_head", 32'(m_tdata), 32'hAA55);
        check("midrst_post_count", 32'(count), 32'd1);

        rst = 1;
        step();
        rst = 0;
        rx.delete();
        sent = 0; cyc = 0;
        while ((sent < 40 || rx.size() < 40) && cyc < 2000) begin
            s_tvalid = (sent < 40) && ($urandom_range(0, 3) != 0);
            s_tdata  = 16'(sent * 16'h0101);
            s_tkeep  = 2'b11;
            m_tready = 1'($urandom_range(0, 1));
            tick(sf);
            if (sf) sent++;
            cyc++;
        end
        check("stream_received", 32'(rx.size()), 32'd40);
        for (int i = 0; i < rx.size() && i < 40; i++)
            check($sformatf("stream_order%0d", i), 32'(rx[i]), 32'(16'(i * 16'h0101)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
